// File: rtl/fp_add_rr_sched.sv
`default_nettype none
// ============================================================================
// fp_add_rr_sched : round-robin scheduler sharing one pipelined fp_add unit
//                   among NUM_REQ requesters, with ID-tagged result routing.
// Revision        : 1.0
// ============================================================================
module fp_add_rr_sched #(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int FPADD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0]     req_rm_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  output logic [2:0]               add_rm_o,
  input  logic [WIDTH-1:0]         add_result_i,
  output logic                     busy_o
);

  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = FPADD_LAT + 1;

  logic [IDW-1:0]             ptr_q, ptr_d;
  logic                       grant_found;
  logic [IDW-1:0]             grant_id;
  logic                       accept;

  logic [WIDTH-1:0]           add_a_q, add_a_d;
  logic [WIDTH-1:0]           add_b_q, add_b_d;
  logic [2:0]                 add_rm_q, add_rm_d;

  logic [STAGES-1:0]          tag_vld_q, tag_vld_d;
  logic [STAGES-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]           rsp_result_q, rsp_result_d;

  // Requester index reached by stepping 'off' places up from p, modulo NUM_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_found && req_valid_i[wrap_idx(ptr_q, off)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(ptr_q, off);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_found && enable_i && !rst) req_ready_o[grant_id] = 1'b1;
  end

  assign accept = |(req_ready_o & req_valid_i);

  always_comb begin
    ptr_d    = ptr_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_rm_d = add_rm_q;
    if (accept) begin
      ptr_d    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      add_a_d  = req_a_i[grant_id*WIDTH +: WIDTH];
      add_b_d  = req_b_i[grant_id*WIDTH +: WIDTH];
      add_rm_d = req_rm_i[grant_id*3 +: 3];
    end
  end

  // Stage FPADD_LAT lines up with add_result_i for the op it describes.
  always_comb begin
    tag_vld_d = {tag_vld_q[STAGES-2:0], accept};
    tag_id_d  = {tag_id_q[STAGES-2:0], grant_id};
  end

  always_comb begin
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    if (tag_vld_q[FPADD_LAT]) begin
      rsp_valid_d[tag_id_q[FPADD_LAT]] = 1'b1;
      rsp_result_d                     = add_result_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_rm_q     <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_rm_q     <= add_rm_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign add_a_o      = add_a_q;
  assign add_b_o      = add_b_q;
  assign add_rm_o     = add_rm_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = (|tag_vld_q) | accept;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_rr_sched.sv
`default_nettype none
// ============================================================================
// tb_fp_add_rr_sched : directed bench for fp_add_rr_sched with an fp_add stand-in.
// Revision           : 1.0
// ============================================================================
module tb_fp_add_rr_sched;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_rm;
  logic [W-1:0]   rsp_result, add_a, add_b, add_result;
  logic [2:0]     add_rm;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_add_rr_sched #(.WIDTH(W), .NUM_REQ(N), .FPADD_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_rm_i     (req_rm),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_rm_o     (add_rm),
    .add_result_i (add_result),
    .busy_o       (busy)
  );

  // fp_add stand-in: hand-computed binary16 sums for the operand pairs used here.
  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      32'h3C00_3C00: return 16'h4000;  // 1.0 + 1.0 = 2.0
      32'h4000_3C00: return 16'h4200;  // 2.0 + 1.0 = 3.0
      32'h3800_3800: return 16'h3C00;  // 0.5 + 0.5 = 1.0
      32'h4000_4000: return 16'h4400;  // 2.0 + 2.0 = 4.0
      default:       return 16'h7E00;
    endcase
  endfunction

  logic [W-1:0] fa_pipe [LAT];
  always @(posedge clk) begin
    fa_pipe[0] <= ref_add(add_a, add_b);
    for (int i = 1; i < LAT; i++) fa_pipe[i] <= fa_pipe[i-1];
  end
  assign add_result = fa_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [N-1:0] v, input logic [W-1:0] r);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
    if (v != '0) chk({tag, ".rsp_result"}, 32'(rsp_result), 32'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic en);
    req_valid = v;
    enable    = en;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Requester i: req0 1+1, req1 2+1, req2 0.5+0.5, req3 2+2; rm = i.
    req_a     = {16'h4000, 16'h3800, 16'h4000, 16'h3C00};
    req_b     = {16'h4000, 16'h3800, 16'h3C00, 16'h3C00};
    req_rm    = {3'd3, 3'd2, 3'd1, 3'd0};
    rst       = 1'b1;
    enable    = 1'b1;
    req_valid = '0;

    // Reset state; grants stay off while rst is high even with valid set.
    tick();
    drive(4'b1111, 1'b1);
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_result", 32'(rsp_result), 32'h0);
    chk("rst.add_a", 32'(add_a), 32'h0);
    chk("rst.add_b", 32'(add_b), 32'h0);
    chk("rst.add_rm", 32'(add_rm), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    drive(4'b0000, 1'b1);
    rst = 1'b0;

    // Single op from requester 0: accept k, issue k+1, response k+4.
    tick(); drive(4'b0001, 1'b1);
    chk("t1.ready", 32'(req_ready), 32'h1);
    chk("t1.busy_acc", 32'(busy), 32'h1);
    tick(); drive(4'b0000, 1'b1);
    chk("t1.ready_off", 32'(req_ready), 32'h0);
    chk("t1.add_a", 32'(add_a), 32'h3C00);
    chk("t1.add_b", 32'(add_b), 32'h3C00);
    chk("t1.add_rm", 32'(add_rm), 32'h0);
    chk_rsp("t1.k1", 4'b0000, 16'h0);
    tick(); chk_rsp("t1.k2", 4'b0000, 16'h0);
    tick(); chk_rsp("t1.k3", 4'b0000, 16'h0);
    chk("t1.busy_fly", 32'(busy), 32'h1);
    tick(); chk_rsp("t1.k4", 4'b0001, 16'h4000);
    tick(); chk_rsp("t1.k5", 4'b0000, 16'h0);
    chk("t1.busy_idle", 32'(busy), 32'h0);

    // All four valid from reset: grants 0,1,2,3 back to back.
    rst = 1'b1; drive(4'b1111, 1'b1);
    chk("t2.ready_rst", 32'(req_ready), 32'h0);
    tick(); rst = 1'b0; drive(4'b1111, 1'b1);
    chk("t2.c0.ready", 32'(req_ready), 32'h1);
    tick(); drive(4'b1111, 1'b1);
    chk("t2.c1.ready", 32'(req_ready), 32'h2);
    chk("t2.c1.add_a", 32'(add_a), 32'h3C00);
    chk("t2.c1.add_rm", 32'(add_rm), 32'h0);
    tick(); drive(4'b1111, 1'b1);
    chk("t2.c2.ready", 32'(req_ready), 32'h4);
    chk("t2.c2.add_a", 32'(add_a), 32'h4000);
    chk("t2.c2.add_b", 32'(add_b), 32'h3C00);
    chk("t2.c2.add_rm", 32'(add_rm), 32'h1);
    tick(); drive(4'b1111, 1'b1);
    chk("t2.c3.ready", 32'(req_ready), 32'h8);
    chk("t2.c3.add_a", 32'(add_a), 32'h3800);
    chk("t2.c3.add_rm", 32'(add_rm), 32'h2);
    tick(); drive(4'b0000, 1'b1);
    chk("t2.c4.ready", 32'(req_ready), 32'h0);
    chk("t2.c4.add_b", 32'(add_b), 32'h4000);
    chk("t2.c4.add_rm", 32'(add_rm), 32'h3);
    chk_rsp("t2.c4", 4'b0001, 16'h4000);
    tick(); chk_rsp("t2.c5", 4'b0010, 16'h4200);
    tick(); chk_rsp("t2.c6", 4'b0100, 16'h3C00);
    tick(); chk_rsp("t2.c7", 4'b1000, 16'h4400);
    tick(); chk_rsp("t2.c8", 4'b0000, 16'h0);
    chk("t2.busy", 32'(busy), 32'h0);

    // Wrap: grant 2 moves ptr to 3; 3 then wins over 0, then 0 is served.
    tick(); drive(4'b0100, 1'b1);
    chk("t3.c0.ready", 32'(req_ready), 32'h4);
    tick(); drive(4'b1001, 1'b1);
    chk("t3.c1.ready", 32'(req_ready), 32'h8);
    tick(); drive(4'b1001, 1'b1);
    chk("t3.c2.ready", 32'(req_ready), 32'h1);
    tick(); drive(4'b1000, 1'b1);
    chk("t3.c3.ready", 32'(req_ready), 32'h8);
    tick(); drive(4'b0000, 1'b1);
    chk_rsp("t3.c4", 4'b0100, 16'h3C00);
    tick(); chk_rsp("t3.c5", 4'b1000, 16'h4400);
    tick(); chk_rsp("t3.c6", 4'b0001, 16'h4000);
    tick(); chk_rsp("t3.c7", 4'b1000, 16'h4400);
    tick(); chk_rsp("t3.c8", 4'b0000, 16'h0);

    // Three accepts, then enable drops with valid still high; in-flight ops drain.
    tick(); drive(4'b1111, 1'b1);
    chk("t4.c0.ready", 32'(req_ready), 32'h1);
    tick(); drive(4'b1111, 1'b1);
    chk("t4.c1.ready", 32'(req_ready), 32'h2);
    tick(); drive(4'b1111, 1'b1);
    chk("t4.c2.ready", 32'(req_ready), 32'h4);
    tick(); drive(4'b1111, 1'b0);
    chk("t4.c3.ready", 32'(req_ready), 32'h0);
    chk("t4.c3.busy", 32'(busy), 32'h1);
    tick(); drive(4'b1111, 1'b0);
    chk("t4.c4.ready", 32'(req_ready), 32'h0);
    chk_rsp("t4.c4", 4'b0001, 16'h4000);
    tick(); chk_rsp("t4.c5", 4'b0010, 16'h4200);
    chk("t4.c5.busy", 32'(busy), 32'h1);
    tick(); chk_rsp("t4.c6", 4'b0100, 16'h3C00);
    tick(); chk_rsp("t4.c7", 4'b0000, 16'h0);
    chk("t4.c7.busy", 32'(busy), 32'h0);
    chk("t4.c7.ready", 32'(req_ready), 32'h0);
    drive(4'b0000, 1'b1);

    // Reset with two ops in flight: nothing comes back, ptr restarts at 0.
    tick(); drive(4'b0011, 1'b1);
    chk("t5.c0.ready", 32'(req_ready), 32'h1);
    tick(); drive(4'b0011, 1'b1);
    chk("t5.c1.ready", 32'(req_ready), 32'h2);
    tick(); rst = 1'b1; drive(4'b0000, 1'b1);
    chk("t5.c2.ready", 32'(req_ready), 32'h0);
    tick(); rst = 1'b0; drive(4'b0000, 1'b1);
    chk_rsp("t5.c3", 4'b0000, 16'h0);
    chk("t5.c3.rsp_result", 32'(rsp_result), 32'h0);
    chk("t5.c3.add_a", 32'(add_a), 32'h0);
    chk("t5.c3.busy", 32'(busy), 32'h0);
    tick(); drive(4'b1010, 1'b1);
    chk_rsp("t5.c4", 4'b0000, 16'h0);
    chk("t5.c4.ready", 32'(req_ready), 32'h2);
    tick(); drive(4'b0000, 1'b1);
    chk_rsp("t5.c5", 4'b0000, 16'h0);
    chk("t5.c5.add_a", 32'(add_a), 32'h4000);
    chk("t5.c5.add_rm", 32'(add_rm), 32'h1);
    tick(); chk_rsp("t5.c6", 4'b0000, 16'h0);
    tick(); chk_rsp("t5.c7", 4'b0000, 16'h0);
    tick(); chk_rsp("t5.c8", 4'b0010, 16'h4200);
    tick(); chk("t5.c9.busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
